// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared types and constants for the pipeline stall/flush controller
// Purpose: state enum, per-stage control struct and the x0 register constant.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } stall_state_t;

  // One hold/bubble bit per stage register; field order matches the bench's ctl vector.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } stage_ctl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam stage_ctl_t CTL_NONE = '0;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard inputs and stall/flush outputs of the stall controller
// Purpose: bundles pipeline-side hazard information and the controller's strobes/counters.
// Ports: master = pipeline side (drives hazard inputs, reads strobes);
//        slave  = stall controller (reads hazard inputs, drives strobes, counters, mem_timeout).
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_reg_a;
  logic [4:0]       id_reg_b;
  logic             id_uses_a;
  logic             id_uses_b;
  logic             ex_mem_read;
  logic [4:0]       ex_reg_write_addr;
  logic             ex_branch_taken;
  logic             ex_muldiv;
  logic             dm_req;
  logic             dm_ack;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             stall_m;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic             flush_w;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output id_reg_a, id_reg_b, id_uses_a, id_uses_b, ex_mem_read, ex_reg_write_addr,
           ex_branch_taken, ex_muldiv, dm_req, dm_ack,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           stall_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  id_reg_a, id_reg_b, id_uses_a, id_uses_b, ex_mem_read, ex_reg_write_addr,
           ex_branch_taken, ex_muldiv, dm_req, dm_ack,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           stall_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// rtl/pipeline_stall_controller_load_use_detect.sv - combinational load-use hazard compare
// Purpose: flags a D-stage source register that matches the rd of a load in E.
// Ports: i_id_reg_a/i_id_reg_b + i_id_uses_a/i_id_uses_b (D sources), i_ex_mem_read,
//        i_ex_reg_write_addr (E load), o_load_use (hazard present).
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_reg_a,
  input  logic [4:0] i_id_reg_b,
  input  logic       i_id_uses_a,
  input  logic       i_id_uses_b,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_reg_write_addr,
  output logic       o_load_use
);
  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a = i_id_uses_a & (i_id_reg_a == i_ex_reg_write_addr);
  assign w_hit_b = i_id_uses_b & (i_id_reg_b == i_ex_reg_write_addr);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_load_use = i_ex_mem_read & (i_ex_reg_write_addr != REG_ZERO) & (w_hit_a | w_hit_b);
endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - per-stage stall/flush generation for a 5-stage pipeline
// Purpose: resolves memory wait, mul/div occupancy, taken branches and load-use hazards
//          into stall/flush strobes; counts stall cycles and redirects; flags memory timeout.
// Ports: clk, rst (sync active-high); bus (slave modport) carries hazard inputs,
//        stall_f..stall_m, flush_d..flush_w, stall_cycles, flush_count, mem_timeout.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int MEM_TIMEOUT    = 256,
  parameter int CNT_W          = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_controller_if.slave  bus
);
  localparam int   MC_W     = $clog2(MULDIV_LATENCY + 1);
  localparam int   WT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic MD_MULTI = 1'(MULDIV_LATENCY > 1);
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MULDIV_LATENCY - 1);

  stall_state_t     r_state;
  logic [MC_W-1:0]  r_mcnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             r_mem_timeout;

  logic       w_memwait;
  logic       w_load_use;
  logic       w_mdbusy;
  logic       w_redirect;
  stage_ctl_t w_ctl;

  load_use_detect u_load_use_detect (
    .i_id_reg_a          (bus.id_reg_a),
    .i_id_reg_b          (bus.id_reg_b),
    .i_id_uses_a         (bus.id_uses_a),
    .i_id_uses_b         (bus.id_uses_b),
    .i_ex_mem_read       (bus.ex_mem_read),
    .i_ex_reg_write_addr (bus.ex_reg_write_addr),
    .o_load_use          (w_load_use)
  );

  assign w_memwait = bus.dm_req & ~bus.dm_ack;
  // The first mul/div cycle is seen in RUN, so it stalls before the FSM has moved.
  assign w_mdbusy  = ((r_state == RUN) & bus.ex_muldiv & MD_MULTI) | (r_state == MULDIV);

  always_comb begin
    w_ctl      = CTL_NONE;
    w_redirect = 1'b0;
    if (!rst) begin
      if (w_memwait) begin
        // Whole front of the pipe freezes; a pending branch stays in E and is re-evaluated later.
        w_ctl.stall_f = 1'b1;
        w_ctl.stall_d = 1'b1;
        w_ctl.stall_e = 1'b1;
        w_ctl.stall_m = 1'b1;
        w_ctl.flush_w = 1'b1;
      end else if (w_mdbusy) begin
        w_ctl.stall_f = 1'b1;
        w_ctl.stall_d = 1'b1;
        w_ctl.stall_e = 1'b1;
        w_ctl.flush_m = 1'b1;
      end else if (bus.ex_branch_taken) begin
        // The D instruction is wrong-path, so any load-use on it is moot.
        w_ctl.flush_d = 1'b1;
        w_ctl.flush_e = 1'b1;
        w_redirect    = 1'b1;
      end else if (w_load_use) begin
        w_ctl.stall_f = 1'b1;
        w_ctl.stall_d = 1'b1;
        w_ctl.flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_mcnt         <= '0;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      if (w_ctl.stall_f) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_redirect)    r_flush_count  <= r_flush_count + CNT_W'(1);

      if (w_memwait) begin
        if (r_wait_cnt != WT_W'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + WT_W'(1);
        if (r_wait_cnt == WT_W'(MEM_TIMEOUT - 1)) r_mem_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      // Memory wait freezes the mul/div sequence in place.
      if (!w_memwait) begin
        case (r_state)
          RUN: begin
            if (bus.ex_muldiv && MD_MULTI) begin
              r_state <= MULDIV;
              r_mcnt  <= MC_LOAD;
            end
          end
          MULDIV: begin
            if (r_mcnt > MC_W'(1)) begin
              r_mcnt <= r_mcnt - MC_W'(1);
            end else begin
              r_state <= RUN;
              r_mcnt  <= '0;
            end
          end
          default: r_state <= RUN;
        endcase
      end
    end
  end

  assign bus.stall_f      = w_ctl.stall_f;
  assign bus.stall_d      = w_ctl.stall_d;
  assign bus.stall_e      = w_ctl.stall_e;
  assign bus.stall_m      = w_ctl.stall_m;
  assign bus.flush_d      = w_ctl.flush_d;
  assign bus.flush_e      = w_ctl.flush_e;
  assign bus.flush_m      = w_ctl.flush_m;
  assign bus.flush_w      = w_ctl.flush_w;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
  assign bus.mem_timeout  = r_mem_timeout;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_LU   = 8'hC4;
  localparam logic [7:0] C_BR   = 8'h0C;
  localparam logic [7:0] C_MD   = 8'hE2;
  localparam logic [7:0] C_MW   = 8'hF1;

  typedef struct {
    int          id;
    logic [7:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;
  exp_t q[$];

  pipeline_stall_controller_if #(.CNT_W(32)) bus ();

  pipeline_stall_controller #(
    .MULDIV_LATENCY (4),
    .MEM_TIMEOUT    (8),
    .CNT_W          (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                      input logic ua, input logic ub, input logic mr, input logic [4:0] wa,
                      input logic br, input logic md, input logic req, input logic ack,
                      input logic [7:0] ctl, input int sc, input int fc, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst                   = r;
    bus.id_reg_a          = ra;
    bus.id_reg_b          = rb;
    bus.id_uses_a         = ua;
    bus.id_uses_b         = ub;
    bus.ex_mem_read       = mr;
    bus.ex_reg_write_addr = wa;
    bus.ex_branch_taken   = br;
    bus.ex_muldiv         = md;
    bus.dm_req            = req;
    bus.dm_ack            = ack;
    e.id  = vid;
    e.ctl = ctl;
    e.sc  = 32'(sc);
    e.fc  = 32'(fc);
    e.to  = to;
    q.push_back(e);
    vid++;
  endtask

  // Monitor: every cycle the DUT presents a fresh strobe set; compare against the oldest expectation.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        n_vec++;
        act = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
               bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w};
        if (act !== e.ctl) begin
          n_err++;
          $display("FAIL vec%0d ctl: got %b want %b", e.id, act, e.ctl);
        end
        if (bus.stall_cycles !== e.sc) begin
          n_err++;
          $display("FAIL vec%0d stall_cycles: got %0d want %0d", e.id, bus.stall_cycles, e.sc);
        end
        if (bus.flush_count !== e.fc) begin
          n_err++;
          $display("FAIL vec%0d flush_count: got %0d want %0d", e.id, bus.flush_count, e.fc);
        end
        if (bus.mem_timeout !== e.to) begin
          n_err++;
          $display("FAIL vec%0d mem_timeout: got %b want %b", e.id, bus.mem_timeout, e.to);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.id_reg_a = '0; bus.id_reg_b = '0; bus.id_uses_a = 0; bus.id_uses_b = 0;
    bus.ex_mem_read = 0; bus.ex_reg_write_addr = '0; bus.ex_branch_taken = 0;
    bus.ex_muldiv = 0; bus.dm_req = 0; bus.dm_ack = 0;
    repeat (2) @(posedge clk);

    //   rst ra rb ua ub mr wa br md rq ak  ctl    sc fc to
    step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0, C_NONE, 0, 0, 0);  // 0 reset gates a hazard
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);  // 1 idle
    step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0, C_LU,   0, 0, 0);  // 2 load x5, rs1=x5
    step(0, 5, 0, 1, 0, 0, 5, 0, 0, 0, 0, C_NONE, 1, 0, 0);  // 3 one bubble only
    step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, C_NONE, 1, 0, 0);  // 4 load x0 never hazards
    step(0, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, C_LU,   1, 0, 0);  // 5 rs2 hazard
    step(0, 0, 7, 0, 0, 1, 7, 0, 0, 0, 0, C_NONE, 2, 0, 0);  // 6 rs2 not used
    step(0, 5, 0, 1, 0, 1, 5, 1, 0, 0, 0, C_BR,   2, 0, 0);  // 7 branch beats load-use
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2, 1, 0);  // 8
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   2, 1, 0);  // 9 mul/div cycle 1
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   3, 1, 0);  // 10
    step(0, 5, 0, 1, 0, 1, 5, 0, 1, 0, 0, C_MD,   4, 1, 0);  // 11 load-use ignored
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   5, 1, 0);  // 12 last stall cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   6, 1, 0);  // 13 back-to-back start
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 7, 1, 0);  // 14 rst in 2nd cycle
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);  // 15 back in RUN, cleared
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_MW,   0, 0, 0);  // 16 memwait over branch
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_MW,   1, 0, 0);  // 17
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_MW,   2, 0, 0);  // 18
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, C_BR,   3, 0, 0);  // 19 ack: branch resolves
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 3, 1, 0);  // 20
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   3, 1, 0);  // 21 mul/div start
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MW,   4, 1, 0);  // 22 memwait freezes mcnt
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   5, 1, 0);  // 23
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   6, 1, 0);  // 24
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_MD,   7, 1, 0);  // 25
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 8, 1, 0);  // 26
    for (int i = 0; i < 10; i++)                               // 27..36 long memwait
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW, 8 + i, 1, (i >= 8) ? 1'b1 : 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 18, 1, 1); // 37 sticky after ack
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 18, 1, 1); // 38
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 18, 1, 1); // 39 rst
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, 0, 0);  // 40 cleared

    @(posedge clk);
    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Stall/flush side of pipeline hazard handling; the forwarding unit covers the data-bypass side.
- Sits beside the 5-stage pipeline (F, D, E, M, W).
- Produces per-stage stall/flush strobes for load-use hazards, taken-branch redirects, multi-cycle mul/div occupancy in E, and data-memory wait states.
- Keeps stall/flush event counters and a sticky memory-timeout error.

Parameters:
- MULDIV_LATENCY, 4, total E-stage cycles a mul/div occupies (>=1).
- MEM_TIMEOUT, 256, consecutive memory-wait cycles before mem_timeout sets.
- CNT_W, 32, width of event counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_reg_a  input  5  rs1 of instruction in D.
- id_reg_b  input  5  rs2 of instruction in D.
- id_uses_a  input  1  D instruction reads rs1.
- id_uses_b  input  1  D instruction reads rs2.
- ex_mem_read  input  1  E instruction is a load.
- ex_reg_write_addr  input  5  rd of E instruction.
- ex_branch_taken  input  1  E resolved a redirect (branch taken / jump).
- ex_muldiv  input  1  level; E holds a mul/div op.
- dm_req  input  1  M stage has an active data-memory access.
- dm_ack  input  1  data memory completes access this cycle.
- stall_f, stall_d, stall_e, stall_m  output  1 each  hold stage register at next edge.
- flush_d, flush_e, flush_m, flush_w  output  1 each  load bubble into stage register at next edge.
- stall_cycles  output  CNT_W  cycles with stall_f high.
- flush_count  output  CNT_W  branch redirects taken.
- mem_timeout  output  1  sticky error.

Behaviour:
- Reset: clk and rst only. Synchronous, active-high. While rst is high all stall/flush outputs are 0. The cycle after release: FSM=RUN, counters=0, mem_timeout=0.
- FSM states: RUN, MULDIV. Down-counter mcnt has width $clog2(MULDIV_LATENCY+1).
- memwait = dm_req & ~dm_ack. Combinational, in any state.
- loaduse = ex_mem_read & ex_reg_write_addr!=0 & ((id_uses_a & id_reg_a==ex_reg_write_addr) | (id_uses_b & id_reg_b==ex_reg_write_addr)).
- mdbusy = (RUN & ex_muldiv & MULDIV_LATENCY>1) | MULDIV.
- Priority (highest first), outputs are the union as listed:
  1. memwait: stall_f/d/e/m=1, flush_w=1. All other flushes suppressed; the branch stays in E and is re-evaluated after release. mcnt frozen.
  2. mdbusy: stall_f/d/e=1, flush_m=1. loaduse ignored.
  3. ex_branch_taken: flush_d=1, flush_e=1. Overrides loaduse, since the D instruction is wrong-path. flush_count += 1.
  4. loaduse: stall_f=1, stall_d=1, flush_e=1. Exactly one bubble cycle.
- RUN -> MULDIV when ex_muldiv & ~memwait & MULDIV_LATENCY>1. mcnt loads MULDIV_LATENCY-1.
- In MULDIV, when ~memwait:
  - mcnt>1: decrement.
  - mcnt==1: return to RUN. Stalls are still asserted in this final cycle; E advances at the following edge.
  - Total mul/div stall cycles = MULDIV_LATENCY plus any memwait cycles.
- MULDIV_LATENCY==1: ex_muldiv causes no stall and no state change.
- Back-to-back mul/div: ex_muldiv high in RUN on the cycle after a return starts a new sequence.
- stall_cycles increments every cycle stall_f=1 and wraps modulo 2^CNT_W. flush_count also wraps.
- Wait counter increments during memwait and clears when memwait=0. When it reaches MEM_TIMEOUT, mem_timeout sets and holds until rst. Stalls continue regardless.
- x0 never produces a load-use hazard.
- Reset asserted mid-MULDIV or mid-memwait: outputs drop to 0 that cycle, state returns to RUN.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - stall_state_t enum {RUN, MULDIV};
  - stage-control struct (stall, flush bits per stage);
  - constant REG_ZERO=5'd0.
- Sub-module load_use_detect: combinational load-use compare, reusable by a future dual-issue decode.

Test Plan:
- Load x5 in E, D reads rs1=x5 with id_uses_a=1 -> one cycle stall_f=stall_d=flush_e=1, next cycle all 0. Repeat with rd=x0 -> no stall.
- ex_branch_taken=1 together with loaduse -> flush_d=flush_e=1, stall_f=0, flush_count 0->1.
- ex_muldiv=1 with MULDIV_LATENCY=4 -> stall_f/d/e=flush_m=1 for exactly 4 cycles, then RUN; stall_cycles=4.
- dm_req=1, dm_ack=0 for 3 cycles during a taken branch -> stall_f..m=flush_w=1 with flush_d/e=0 for 3 cycles; on the ack cycle flush_d=flush_e=1.
- Memwait with MEM_TIMEOUT=8 for 10 cycles -> mem_timeout rises after 8 wait cycles, stays 1 after ack, clears only on rst.
- rst pulsed in the 2nd MULDIV cycle -> outputs 0 that cycle; after release state=RUN and counters=0.
